vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port synchronous display RAM between the 6502 bus and
//  the character-fetch side of the video generator in the uk101 core.
//  Video fetches have priority; a starvation guard bounds CPU wait.
//  Pipelined: one RAM access per clk, fixed 3-cycle request-to-data latency.
// PARAMETERS
//  ADDR_W     11  RAM address width (2 KB covers 64x32 and 48x16 screens)
//  DATA_W      8  RAM data width
//  STARVE_MAX  4  consecutive cycles a pending CPU access may lose before it
//                 is forced to win (1..15)
// PORTS
//  clk        in   1       system clock; all logic on rising edge
//  n_reset    in   1       asynchronous, active-low reset
//  cpu_req    in   1       1-cycle pulse: start CPU access (ignored if cpu_busy)
//  cpu_we     in   1       1=write, 0=read; sampled with cpu_req
//  cpu_addr   in   ADDR_W  sampled with cpu_req
//  cpu_wdata  in   DATA_W  sampled with cpu_req
//  cpu_busy   out  1       CPU access accepted, not yet acked
//  cpu_ack    out  1       1-cycle pulse: access done; cpu_rdata valid (reads)
//  cpu_rdata  out  DATA_W  read data, held until next CPU read ack
//  vid_req    in   1       1-cycle pulse: character fetch request
//  vid_addr   in   ADDR_W  sampled with vid_req
//  vid_valid  out  1       1-cycle pulse: vid_rdata valid
//  vid_rdata  out  DATA_W  fetched character code, held until next vid_valid
//  vid_ovf    out  1       sticky: a pending video request was overwritten
//  ram_addr   out  ADDR_W  RAM address (registered)
//  ram_we     out  1       RAM write strobe (registered, 1 cycle)
//  ram_wdata  out  DATA_W  RAM write data (registered)
//  ram_rdata  in   DATA_W  RAM read data, valid 1 cycle after ram_addr
// BEHAVIOUR
//  Reset (async, n_reset=0): all outputs 0, pending flags, starve counter
//   and pipeline slots cleared; in-flight accesses dropped (no ack/valid).
//  Candidates each cycle T: video = vid_req | vid_pend; CPU = cpu_pend
//   (cpu_pend is not set yet in the cycle cpu_req arrives; request pulses
//   are also candidates in their own cycle: vid_req or cpu_req&~cpu_busy).
//  Grant: video wins unless starve_cnt==STARVE_MAX and CPU candidate exists.
//  Loser stays pending. Exactly one grant or none per cycle.
//  Issue stage S1 (T+1): ram_addr/ram_we/ram_wdata registered from winner;
//   ram_we=1 only for CPU write; idle cycle keeps ram_addr, ram_we=0.
//  Data stage S2 (T+2): ram_rdata sampled with owner tag from S1.
//  Return (T+3): owner VID -> vid_valid=1, vid_rdata=data; owner CPU ->
//   cpu_ack=1 (reads and writes), cpu_rdata=data for reads only.
//  Minimum latency request pulse -> ack/valid = 3 cycles.
//  cpu_busy: 1 from T+1 of accepted cpu_req through the cpu_ack cycle;
//   0 the cycle after. cpu_req while cpu_busy=1 is ignored.
//  vid_pend: set when vid_req loses; cleared when granted. vid_req while
//   vid_pend=1 and not granted: newer address replaces old, vid_ovf<=1
//   (sticky until reset); only the newer fetch is returned.
//  starve_cnt (4 bit): +1 each cycle CPU candidate loses; 0 on CPU grant or
//   no CPU candidate; saturates at STARVE_MAX.
//  Simultaneous vid_req and cpu_req, idle: video issues T+1, CPU T+2.
//  Back-to-back: a vid_req every cycle sustains 1 fetch/cycle, each
//   returned in order; CPU forced in after STARVE_MAX losses.
// TESTING
//  Reset: drop n_reset mid-access -> all outputs 0 immediately, no late ack.
//  Lone CPU write addr 0x123 data 0x41 at T -> ram_we=1 T+1, cpu_ack T+3;
//   then read 0x123 -> cpu_ack with cpu_rdata=0x41 three cycles later.
//  vid_req 0x010 and cpu_req 0x020 same cycle T -> ram_addr 0x010 at T+1,
//   0x020 at T+2; vid_valid T+3, cpu_ack T+4.
//  vid_req every cycle, CPU read pending, STARVE_MAX=4 -> CPU granted on its
//   5th candidate cycle; video fetches resume next cycle, no fetch lost.
//  Two vid_req while first pending (CPU forced win) -> vid_ovf=1, single
//   vid_valid carrying second address's data.
//  cpu_req pulsed while cpu_busy=1 -> ignored; exactly one cpu_ack.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter
//
// Shares one single-port synchronous display RAM between the 6502 bus and the
// character-fetch side of the video generator. Video fetches normally win;
// a starvation counter forces a waiting CPU access through after STARVE_MAX
// consecutive losses. One RAM access per clock, fixed 3-cycle latency from
// a winning request to its ack/valid pulse.
//
// Ports
//   clk, n_reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU access request (1-cycle pulse)
//   cpu_busy                     CPU access accepted and not yet acked
//   cpu_ack, cpu_rdata           completion pulse; read data held until next read ack
//   vid_req, vid_addr            character fetch request (1-cycle pulse)
//   vid_valid, vid_rdata         fetch return pulse; data held until next valid
//   vid_ovf                      sticky: a pending fetch was replaced before issue
//   ram_addr/we/wdata            registered RAM command
//   ram_rdata                    RAM read data, valid one cycle after ram_addr
//
// Pipeline: T arbitrate -> T+1 RAM command (S1) -> T+2 RAM data (S2)
//           -> T+3 registered ack/valid.

module vram_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ovf,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    // Request holding state
    logic              vid_pend_q, vid_pend_d;
    logic [ADDR_W-1:0] vid_pend_addr_q, vid_pend_addr_d;
    logic              vid_ovf_q, vid_ovf_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_busy_q, cpu_busy_d;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic [3:0]        starve_q, starve_d;

    // S1: RAM command plus owner tag
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_cpu_q, s1_cpu_d;
    logic              s1_rd_q, s1_rd_d;

    // S2: owner tag aligned with ram_rdata
    logic              s2_valid_q, s2_valid_d;
    logic              s2_cpu_q, s2_cpu_d;
    logic              s2_rd_q, s2_rd_d;

    // Return stage
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

    // Arbitration signals
    logic              cpu_new;
    logic              cpu_cand;
    logic              vid_cand;
    logic              cpu_forced;
    logic              grant_vid;
    logic              grant_cpu;
    logic [ADDR_W-1:0] vid_sel_addr;
    logic              cpu_sel_we;
    logic [ADDR_W-1:0] cpu_sel_addr;
    logic [DATA_W-1:0] cpu_sel_wdata;

    always_comb begin
        cpu_new    = cpu_req & ~cpu_busy_q;
        cpu_cand   = cpu_pend_q | cpu_new;
        vid_cand   = vid_req | vid_pend_q;
        cpu_forced = cpu_cand & (starve_q == StarveMax);
        grant_vid  = vid_cand & ~cpu_forced;
        grant_cpu  = cpu_cand & ~grant_vid;

        // The older pending fetch issues first; a fresh request behind it waits.
        vid_sel_addr  = vid_pend_q ? vid_pend_addr_q : vid_addr;
        cpu_sel_we    = cpu_pend_q ? cpu_we_q : cpu_we;
        cpu_sel_addr  = cpu_pend_q ? cpu_addr_q : cpu_addr;
        cpu_sel_wdata = cpu_pend_q ? cpu_wdata_q : cpu_wdata;
    end

    // Next-state for request holding state
    always_comb begin
        vid_pend_d      = vid_pend_q;
        vid_pend_addr_d = vid_pend_addr_q;
        vid_ovf_d       = vid_ovf_q;
        cpu_pend_d      = cpu_pend_q;
        cpu_busy_d      = cpu_busy_q;
        cpu_we_d        = cpu_we_q;
        cpu_addr_d      = cpu_addr_q;
        cpu_wdata_d     = cpu_wdata_q;
        starve_d        = starve_q;

        // A new request is parked unless it is the one being issued right now.
        if (vid_req && (vid_pend_q || !grant_vid)) begin
            vid_pend_d      = 1'b1;
            vid_pend_addr_d = vid_addr;
            if (vid_pend_q && !grant_vid) begin
                vid_ovf_d = 1'b1;
            end
        end else if (grant_vid) begin
            vid_pend_d = 1'b0;
        end

        if (cpu_new) begin
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end

        if (grant_cpu) begin
            cpu_pend_d = 1'b0;
        end else if (cpu_new) begin
            cpu_pend_d = 1'b1;
        end

        // Busy covers acceptance through the ack cycle inclusive.
        cpu_busy_d = cpu_new | (cpu_busy_q & ~cpu_ack_q);

        if (cpu_cand && !grant_cpu) begin
            if (starve_q != StarveMax) begin
                starve_d = starve_q + 4'd1;
            end
        end else begin
            starve_d = 4'd0;
        end
    end

    // Next-state for the access pipeline
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        s1_valid_d  = 1'b0;
        s1_cpu_d    = 1'b0;
        s1_rd_d     = 1'b0;

        if (grant_vid) begin
            ram_addr_d = vid_sel_addr;
            s1_valid_d = 1'b1;
        end else if (grant_cpu) begin
            ram_addr_d  = cpu_sel_addr;
            ram_we_d    = cpu_sel_we;
            ram_wdata_d = cpu_sel_wdata;
            s1_valid_d  = 1'b1;
            s1_cpu_d    = 1'b1;
            s1_rd_d     = ~cpu_sel_we;
        end

        s2_valid_d = s1_valid_q;
        s2_cpu_d   = s1_cpu_q;
        s2_rd_d    = s1_rd_q;

        // ram_rdata is captured straight into the output registers so the
        // return lands on T+3.
        vid_valid_d = s2_valid_q & ~s2_cpu_q;
        vid_rdata_d = vid_valid_d ? ram_rdata : vid_rdata_q;
        cpu_ack_d   = s2_valid_q & s2_cpu_q;
        cpu_rdata_d = (cpu_ack_d && s2_rd_q) ? ram_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vid_pend_q      <= 1'b0;
            vid_pend_addr_q <= '0;
            vid_ovf_q       <= 1'b0;
            cpu_pend_q      <= 1'b0;
            cpu_busy_q      <= 1'b0;
            cpu_we_q        <= 1'b0;
            cpu_addr_q      <= '0;
            cpu_wdata_q     <= '0;
            starve_q        <= 4'd0;
            ram_addr_q      <= '0;
            ram_we_q        <= 1'b0;
            ram_wdata_q     <= '0;
            s1_valid_q      <= 1'b0;
            s1_cpu_q        <= 1'b0;
            s1_rd_q         <= 1'b0;
            s2_valid_q      <= 1'b0;
            s2_cpu_q        <= 1'b0;
            s2_rd_q         <= 1'b0;
            cpu_ack_q       <= 1'b0;
            cpu_rdata_q     <= '0;
            vid_valid_q     <= 1'b0;
            vid_rdata_q     <= '0;
        end else begin
            vid_pend_q      <= vid_pend_d;
            vid_pend_addr_q <= vid_pend_addr_d;
            vid_ovf_q       <= vid_ovf_d;
            cpu_pend_q      <= cpu_pend_d;
            cpu_busy_q      <= cpu_busy_d;
            cpu_we_q        <= cpu_we_d;
            cpu_addr_q      <= cpu_addr_d;
            cpu_wdata_q     <= cpu_wdata_d;
            starve_q        <= starve_d;
            ram_addr_q      <= ram_addr_d;
            ram_we_q        <= ram_we_d;
            ram_wdata_q     <= ram_wdata_d;
            s1_valid_q      <= s1_valid_d;
            s1_cpu_q        <= s1_cpu_d;
            s1_rd_q         <= s1_rd_d;
            s2_valid_q      <= s2_valid_d;
            s2_cpu_q        <= s2_cpu_d;
            s2_rd_q         <= s2_rd_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_rdata_q     <= cpu_rdata_d;
            vid_valid_q     <= vid_valid_d;
            vid_rdata_q     <= vid_rdata_d;
        end
    end

    assign cpu_busy  = cpu_busy_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_valid = vid_valid_q;
    assign vid_rdata = vid_rdata_q;
    assign vid_ovf   = vid_ovf_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a transaction-level reference model.

module tb_vram_arbiter;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              n_reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_busy;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_ovf;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_busy  (cpu_busy),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .vid_ovf   (vid_ovf),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM
    logic [DATA_W-1:0] ram_mem [0:2047];
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Reference model (transaction level) ----------------
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } vexp_t;
    typedef struct {
        int                due;
        bit                rd;
        logic [DATA_W-1:0] data;
    } cexp_t;

    logic [DATA_W-1:0] ref_mem [0:2047];
    logic [ADDR_W-1:0] vq[$];      // video requests waiting, oldest first
    vexp_t             vexp[$];
    cexp_t             cexp[$];
    bit                m_active;   // CPU access accepted, not yet complete
    bit                m_cpu_pend; // accepted, not yet granted
    bit                m_granted;
    int                m_ack_cyc;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    int unsigned       m_loss;
    bit                m_busy_now;
    bit                m_ovf;
    int                m_ovf_cyc;
    logic [DATA_W-1:0] m_last_rd;

    task automatic model_reset();
        vq.delete();
        vexp.delete();
        cexp.delete();
        m_active   = 1'b0;
        m_cpu_pend = 1'b0;
        m_granted  = 1'b0;
        m_ack_cyc  = 0;
        m_loss     = 0;
        m_busy_now = 1'b0;
        m_ovf      = 1'b0;
        m_ovf_cyc  = 0;
        m_last_rd  = '0;
    endtask

    // Apply this cycle's inputs to the model; push the expected returns.
    task automatic model_step();
        int                k;
        bit                cand_v, cand_c, forced, gv, gc;
        logic [ADDR_W-1:0] a;
        k = cyc;
        if (m_active && m_granted && k > m_ack_cyc) m_active = 1'b0;
        m_busy_now = m_active;
        if (vid_req) vq.push_back(vid_addr);
        if (cpu_req && !m_active) begin
            m_active   = 1'b1;
            m_granted  = 1'b0;
            m_cpu_pend = 1'b1;
            m_we       = cpu_we;
            m_addr     = cpu_addr;
            m_wdata    = cpu_wdata;
        end
        cand_v = vq.size() > 0;
        cand_c = m_cpu_pend;
        forced = cand_c && (m_loss == STARVE_MAX);
        gv     = cand_v && !forced;
        gc     = cand_c && !gv;
        if (gv) begin
            a = vq.pop_front();
            vexp.push_back('{due: k + 3, data: ref_mem[a]});
        end
        if (gc) begin
            m_cpu_pend = 1'b0;
            m_granted  = 1'b1;
            m_ack_cyc  = k + 3;
            if (m_we) begin
                ref_mem[m_addr] = m_wdata;
                cexp.push_back('{due: k + 3, rd: 1'b0, data: '0});
            end else begin
                cexp.push_back('{due: k + 3, rd: 1'b1, data: ref_mem[m_addr]});
            end
        end
        // Only one waiting slot: a newer request displaces an older one.
        if (vq.size() > 1) begin
            void'(vq.pop_front());
            if (!m_ovf) m_ovf_cyc = k;
            m_ovf = 1'b1;
        end
        if (cand_c && !gc) m_loss = (m_loss < STARVE_MAX) ? m_loss + 1 : m_loss;
        else               m_loss = 0;
    endtask

    // ---------------- Monitor / scoreboard ----------------
    bit in_reset = 1'b1;
    int vid_count = 0;
    int ack_count = 0;
    int last_ack_cyc = -1;

    always @(negedge clk) begin
        if (!in_reset) begin
            bit    exp_v, exp_c;
            vexp_t ve;
            cexp_t ce;
            check("cpu_busy", 32'(cpu_busy), 32'(m_busy_now));
            check("vid_ovf", 32'(vid_ovf), 32'(m_ovf && (cyc > m_ovf_cyc)));

            exp_v = (vexp.size() > 0) && (vexp[0].due == cyc);
            check("vid_valid", 32'(vid_valid), 32'(exp_v));
            if (vid_valid) vid_count++;
            if (exp_v) begin
                ve = vexp.pop_front();
                if (vid_valid) check("vid_rdata", 32'(vid_rdata), 32'(ve.data));
            end

            exp_c = (cexp.size() > 0) && (cexp[0].due == cyc);
            check("cpu_ack", 32'(cpu_ack), 32'(exp_c));
            if (cpu_ack) begin
                ack_count++;
                last_ack_cyc = cyc;
            end
            if (exp_c) begin
                ce = cexp.pop_front();
                if (ce.rd) m_last_rd = ce.data;
                if (cpu_ack) check("cpu_rdata", 32'(cpu_rdata), 32'(m_last_rd));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        vid_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_busy"}, 32'(cpu_busy), 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
        check({tag, "_vid_rdata"}, 32'(vid_rdata), 32'd0);
        check({tag, "_vid_ovf"}, 32'(vid_ovf), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    task automatic cpu_issue(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic vid_issue(input logic [ADDR_W-1:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
    endtask

    task automatic do_reset();
        n_reset  = 1'b0;
        in_reset = 1'b1;
        #1;
        check_all_zero("reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = ram_mem[i];
        n_reset  = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        int c_req, base_v, base_a;
        for (int i = 0; i < 2048; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        model_reset();
        #2;
        do_reset();
        idle(3);

        // Lone CPU write, then read back
        cpu_issue(1'b1, 11'h123, 8'h41);
        tick();
        check("wr_ram_we", 32'(ram_we), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'h123);
        check("wr_ram_wdata", 32'(ram_wdata), 32'h41);
        tick();
        check("wr_ram_we_pulse", 32'(ram_we), 32'd0);
        tick();
        check("wr_ack_t3", 32'(cpu_ack), 32'd1);
        tick();
        cpu_issue(1'b0, 11'h123, 8'h00);
        idle(3);
        check("rd_ack_t3", 32'(cpu_ack), 32'd1);
        check("rd_data", 32'(cpu_rdata), 32'h41);
        idle(3);

        // Simultaneous video and CPU requests
        vid_issue(11'h010);
        cpu_issue(1'b0, 11'h020, 8'h00);
        tick();
        check("sim_addr_vid", 32'(ram_addr), 32'h010);
        tick();
        check("sim_addr_cpu", 32'(ram_addr), 32'h020);
        tick();
        check("sim_vid_t3", 32'(vid_valid), 32'd1);
        tick();
        check("sim_cpu_t4", 32'(cpu_ack), 32'd1);
        idle(4);

        // cpu_req while busy is ignored
        base_a = ack_count;
        cpu_issue(1'b0, 11'h050, 8'h00);
        tick();
        cpu_issue(1'b1, 11'h060, 8'hEE);
        tick();
        cpu_issue(1'b1, 11'h060, 8'hEE);
        tick();
        idle(6);
        check("busy_single_ack", 32'(ack_count - base_a), 32'd1);

        // Video every cycle with a CPU read pending: forced in on 5th candidate cycle
        base_v = vid_count;
        c_req  = 0;
        for (int i = 0; i < 12; i++) begin
            vid_issue(11'h400 + 11'(i));
            if (i == 1) begin
                cpu_issue(1'b0, 11'h0AA, 8'h00);
                c_req = cyc;
            end
            if (i == 6) check("starve_cpu_issue", 32'(ram_addr), 32'h0AA);
            tick();
        end
        idle(8);
        check("starve_ack_cycle", 32'(last_ack_cyc), 32'(c_req + 7));
        check("starve_no_loss", 32'(vid_count - base_v), 32'd12);

        // Reset mid-access: outputs clear immediately, nothing late
        cpu_issue(1'b1, 11'h100, 8'h55);
        vid_issue(11'h011);
        tick();
        #2;
        base_v = vid_count;
        base_a = ack_count;
        do_reset();
        idle(6);
        check("rst_no_late_vid", 32'(vid_count - base_v), 32'd0);
        check("rst_no_late_ack", 32'(ack_count - base_a), 32'd0);

        // Overflow: continuous video plus repeated CPU reads
        base_v = vid_count;
        for (int i = 0; i < 20; i++) begin
            vid_issue(11'h500 + 11'(i));
            cpu_issue(1'b0, 11'h0C0 + 11'(i), 8'h00);
            tick();
        end
        idle(10);
        check("ovf_sticky", 32'(vid_ovf), 32'd1);
        check("ovf_one_lost", 32'(vid_count - base_v), 32'd19);

        // Randomized traffic on a small address window
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) vid_issue(11'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0)
                cpu_issue(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        idle(10);
        check("drain_vid", 32'(vexp.size()), 32'd0);
        check("drain_cpu", 32'(cexp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
